// File: rtl/i2c_ioexp_target_if.sv
// Open-drain I2C pin bundle between a host (or pad wrapper) and the expander target.
// Latency: wires only; no state.
// Backpressure: none; SCL is observed only and the target never stretches the clock.
//   scl_in   : SCL level seen at the pad
//   sda_in   : SDA level seen at the pad (wired-AND of every driver)
//   sda_oe_n : target SDA pull-down enable, 0 = drive low, 1 = release
`timescale 1ns/1ps
interface i2c_ioexp_target_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe_n;

    modport master (output scl_in, output sda_in, input sda_oe_n);
    modport slave  (input scl_in, input sda_in, output sda_oe_n);
endinterface

// File: rtl/i2c_ioexp_target.sv
// I2C target emulating the input/output/config registers of a PCAL6416A-style 16-bit expander.
// Latency: SYNC_STAGES+1 clk from a pad edge to its detection; SDA changes 1 clk after a detected SCL fall.
// Backpressure: none; every byte is ACKed on a matched address and SCL is never stretched.
//   clk, reset (sync, active-high) | bus : SCL/SDA pins (slave modport)
//   in  : pin values read via regs 0x00/0x01 | out : regs 0x02/0x03 | dir : regs 0x06/0x07 (1 = input)
//   out_update : 1-clk pulse when a write changed out or dir | busy : addressed START until STOP
//   Optional macro I2C_IOEXP_TARGET_IRQ_EN adds irq_n (active-low pin-change interrupt).
`timescale 1ns/1ps
module i2c_ioexp_target #(
    parameter logic [6:0]  ADDR        = 7'h20,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] OUT_RESET   = 16'hFFFF,
    parameter logic [15:0] CFG_RESET   = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_ioexp_target_if.slave     bus,
    input  logic [15:0]           in,
    output logic [15:0]           out,
    output logic [15:0]           dir,
    output logic                  out_update,
    output logic                  busy
`ifdef I2C_IOEXP_TARGET_IRQ_EN
    ,
    output logic                  irq_n
`endif
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_d, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [7:0]  rx, rx_nx, tx, tx_nx, ptr, ptr_nx;
    logic [15:0] snap, snap_nx, out_r, out_nx, dir_r, dir_nx;
    logic        rw, rw_nx, host_ack, host_ack_nx, oe_n, oe_nx;
    logic        upd, upd_nx, busy_r, busy_nx;
    logic [7:0]  rd_ptr, rd_now;
    logic [15:0] in_src;

    function automatic logic [7:0] rd_byte(input logic [7:0] p, input logic [15:0] s,
                                           input logic [15:0] o, input logic [15:0] d);
        case (p)
            8'h00:   return s[7:0];
            8'h01:   return s[15:8];
            8'h02:   return o[7:0];
            8'h03:   return o[15:8];
            8'h06:   return d[7:0];
            8'h07:   return d[15:8];
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    // SCL held high across both samples, so an SDA edge here is a bus condition, not data.
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

`ifdef I2C_IOEXP_TARGET_IRQ_EN
    logic [15:0] in_meta, in_sync, irq_ref;
    logic        irq_r, load_evt;
    assign in_src = in_sync;
`else
    assign in_src = in;
`endif

    // A read byte is loaded either after the address ACK (current pointer) or after a
    // host ACK (pointer already toggled to the pair partner).
    assign rd_ptr = (state == S_RDATA_ACK) ? {ptr[7:1], ~ptr[0]} : ptr;
    assign rd_now = rd_byte(rd_ptr, in_src, out_r, dir_r);

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        rx_nx       = rx;
        tx_nx       = tx;
        ptr_nx      = ptr;
        snap_nx     = snap;
        out_nx      = out_r;
        dir_nx      = dir_r;
        rw_nx       = rw;
        host_ack_nx = host_ack;
        oe_nx       = oe_n;
        busy_nx     = busy_r;
        upd_nx      = 1'b0;
        if (start_det) begin
            state_nx = S_ADDR;
            cnt_nx   = 4'd0;
            oe_nx    = 1'b1;
        end else if (stop_det) begin
            state_nx = S_IDLE;
            oe_nx    = 1'b1;
            busy_nx  = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_REG, S_WDATA: begin
                    if (scl_rise && cnt != 4'd8) begin
                        rx_nx  = {rx[6:0], sda_s};
                        cnt_nx = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        oe_nx = 1'b0;
                        if (state == S_ADDR) begin
                            if (rx[7:1] == ADDR) begin
                                state_nx = S_ADDR_ACK;
                                busy_nx  = 1'b1;
                                rw_nx    = rx[0];
                            end else begin
                                state_nx = S_IDLE;
                                oe_nx    = 1'b1;
                            end
                        end else if (state == S_REG) begin
                            ptr_nx   = rx;
                            state_nx = S_REG_ACK;
                        end else begin
                            state_nx = S_WDATA_ACK;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_nx = 4'd0;
                        if (rw) begin
                            snap_nx  = in_src;
                            tx_nx    = rd_now;
                            oe_nx    = rd_now[7];
                            state_nx = S_RDATA;
                        end else begin
                            oe_nx    = 1'b1;
                            state_nx = S_REG;
                        end
                    end
                end
                S_REG_ACK: begin
                    if (scl_fall) begin
                        oe_nx    = 1'b1;
                        cnt_nx   = 4'd0;
                        state_nx = S_WDATA;
                    end
                end
                S_WDATA_ACK: begin
                    if (scl_fall) begin
                        case (ptr)
                            8'h02:   out_nx[7:0]  = rx;
                            8'h03:   out_nx[15:8] = rx;
                            8'h06:   dir_nx[7:0]  = rx;
                            8'h07:   dir_nx[15:8] = rx;
                            default: ;
                        endcase
                        upd_nx    = (out_nx != out_r) || (dir_nx != dir_r);
                        ptr_nx[0] = ~ptr[0];
                        oe_nx     = 1'b1;
                        cnt_nx    = 4'd0;
                        state_nx  = S_WDATA;
                    end
                end
                S_RDATA: begin
                    if (scl_rise && cnt != 4'd8) begin
                        cnt_nx = cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            oe_nx    = 1'b1;
                            state_nx = S_RDATA_ACK;
                        end else begin
                            tx_nx = {tx[6:0], 1'b0};
                            oe_nx = tx[6];
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (scl_rise) begin
                        host_ack_nx = sda_s;
                    end else if (scl_fall) begin
                        if (!host_ack) begin
                            ptr_nx[0] = ~ptr[0];
                            snap_nx   = in_src;
                            tx_nx     = rd_now;
                            oe_nx     = rd_now[7];
                            cnt_nx    = 4'd0;
                            state_nx  = S_RDATA;
                        end else begin
                            state_nx = S_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            rx       <= 8'h00;
            tx       <= 8'h00;
            ptr      <= 8'h00;
            snap     <= 16'h0000;
            out_r    <= OUT_RESET;
            dir_r    <= CFG_RESET;
            rw       <= 1'b0;
            host_ack <= 1'b1;
            oe_n     <= 1'b1;
            upd      <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            rx       <= rx_nx;
            tx       <= tx_nx;
            ptr      <= ptr_nx;
            snap     <= snap_nx;
            out_r    <= out_nx;
            dir_r    <= dir_nx;
            rw       <= rw_nx;
            host_ack <= host_ack_nx;
            oe_n     <= oe_nx;
            upd      <= upd_nx;
            busy_r   <= busy_nx;
        end
    end

`ifdef I2C_IOEXP_TARGET_IRQ_EN
    // Reference only moves when a byte of register 0x00/0x01 is loaded for the host.
    assign load_evt = scl_fall && !start_det && !stop_det &&
                      ((state == S_ADDR_ACK && rw) || (state == S_RDATA_ACK && !host_ack));

    always_ff @(posedge clk) begin
        if (reset) begin
            in_meta <= 16'h0000;
            in_sync <= 16'h0000;
            irq_ref <= 16'h0000;
            irq_r   <= 1'b1;
        end else begin
            in_meta <= in;
            in_sync <= in_meta;
            if (load_evt && rd_ptr[7:1] == 7'h00)
                irq_ref <= in_src;
            // Clearing on the host-ack clock of an input-register byte wins over a new set.
            if (scl_fall && !start_det && !stop_det && state == S_RDATA_ACK && ptr[7:1] == 7'h00)
                irq_r <= 1'b1;
            else if (|((in_sync ^ irq_ref) & dir_r))
                irq_r <= 1'b0;
        end
    end
    assign irq_n = irq_r;
`endif

    assign bus.sda_oe_n = oe_n;
    assign out          = out_r;
    assign dir          = dir_r;
    assign out_update   = upd;
    assign busy         = busy_r;
endmodule

// File: tb/tb_i2c_ioexp_target.sv
// Self-checking bench for i2c_ioexp_target: a bit-banged I2C host plus scoreboard monitors.
// Latency: host runs SCL at 1/80 of clk; responses are checked after each byte completes.
// Backpressure: none; the host never waits on the target, so every run ends by time.
`timescale 1ns/1ps
module tb_i2c_ioexp_target;
    localparam int Q = 200;  // quarter SCL period in ns

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    i2c_ioexp_target_if bus ();
    logic host_scl = 1'b1;
    logic host_sda = 1'b1;
    assign bus.scl_in = host_scl;
    assign bus.sda_in = host_sda & bus.sda_oe_n;

    logic [15:0] pins = 16'h0000;
    logic [15:0] out, dir;
    logic        out_update, busy;
`ifdef I2C_IOEXP_TARGET_IRQ_EN
    logic        irq_n;
`endif

    i2c_ioexp_target dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .in         (pins),
        .out        (out),
        .dir        (dir),
        .out_update (out_update),
        .busy       (busy)
`ifdef I2C_IOEXP_TARGET_IRQ_EN
        ,
        .irq_n      (irq_n)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int upd_cnt = 0;
    logic watch_low = 1'b0;
    logic saw_low   = 1'b0;

    string       exp_n[$];
    logic [31:0] exp_v[$];
    logic [31:0] obs_q[$];
    logic [31:0] upd_q[$];

    function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endfunction

    // Byte/ACK scoreboard: pops an expectation whenever the host has captured a response.
    initial begin
        logic [31:0] o;
        forever begin
            @(negedge clk);
            if (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                if (exp_v.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_response: got %h required none", o);
                end else begin
                    cmp(exp_n.pop_front(), o, exp_v.pop_front());
                end
            end
        end
    end

    // Register-update scoreboard: every out_update pulse must match the next {dir,out}.
    initial begin
        forever begin
            @(negedge clk);
            if (out_update) begin
                upd_cnt++;
                if (upd_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out_update: got %h required none", {dir, out});
                end else begin
                    cmp("out_update_value", {dir, out}, upd_q.pop_front());
                end
            end
            if (watch_low && !bus.sda_oe_n) saw_low = 1'b1;
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic hbit(input logic b, output logic r);
        host_sda = b;  #(Q);
        host_scl = 1'b1; #(Q);
        r = bus.sda_in; #(Q);
        host_scl = 1'b0; #(Q);
    endtask

    task automatic i2c_start();
        host_sda = 1'b1; #(Q);
        host_scl = 1'b1; #(Q);
        host_sda = 1'b0; #(Q);
        host_scl = 1'b0; #(Q);
    endtask

    task automatic i2c_stop();
        host_sda = 1'b0; #(Q);
        host_scl = 1'b1; #(Q);
        host_sda = 1'b1; #(Q);
    endtask

    task automatic wbyte(input logic [7:0] b, input logic exp_ack, input string nm);
        logic r;
        exp_n.push_back(nm);
        exp_v.push_back(32'(exp_ack));
        for (int i = 7; i >= 0; i--) hbit(b[i], r);
        hbit(1'b1, r);
        obs_q.push_back(32'(r));
    endtask

    task automatic rbyte(input logic [7:0] exp_b, input logic hack, input string nm);
        logic [7:0] v;
        logic r;
        exp_n.push_back(nm);
        exp_v.push_back(32'(exp_b));
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            hbit(1'b1, r);
            v = {v[6:0], r};
        end
        hbit(hack, r);
        obs_q.push_back(32'(v));
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
    endtask

    initial begin
        logic r;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        cmp("reset_sda_oe_n", 32'(bus.sda_oe_n), 32'd1);
        cmp("reset_out", 32'(out), 32'hFFFF);
        cmp("reset_dir", 32'(dir), 32'hFFFF);
        cmp("reset_out_update", 32'(out_update), 32'd0);
        cmp("reset_busy", 32'(busy), 32'd0);

        // Write out pair: 0xA5 -> reg 0x02, 0x3C -> reg 0x03.
        upd_q.push_back({16'hFFFF, 16'hFFA5});
        upd_q.push_back({16'hFFFF, 16'h3CA5});
        i2c_start();
        wbyte(8'h40, 1'b0, "w_addr_ack");
        wbyte(8'h02, 1'b0, "w_reg_ack");
        wbyte(8'hA5, 1'b0, "w_data0_ack");
        wbyte(8'h3C, 1'b0, "w_data1_ack");
        cmp("busy_in_write", 32'(busy), 32'd1);
        i2c_stop();
        settle();
        cmp("busy_after_stop", 32'(busy), 32'd0);
        cmp("out_after_write", 32'(out), 32'h3CA5);
        cmp("update_pulses_write", 32'(upd_cnt), 32'd2);

        // Read config pair through a repeated START; nothing may change.
        i2c_start();
        wbyte(8'h40, 1'b0, "cfg_addr_ack");
        wbyte(8'h06, 1'b0, "cfg_reg_ack");
        i2c_start();
        wbyte(8'h41, 1'b0, "cfg_raddr_ack");
        rbyte(8'hFF, 1'b0, "cfg_rd_06");
        rbyte(8'hFF, 1'b1, "cfg_rd_07");
        i2c_stop();
        settle();
        cmp("update_pulses_cfg_read", 32'(upd_cnt), 32'd2);

        // Write dir low byte, then read without a register byte: pointer sits at 0x07.
        upd_q.push_back({16'hFF0F, 16'h3CA5});
        i2c_start();
        wbyte(8'h40, 1'b0, "dir_addr_ack");
        wbyte(8'h06, 1'b0, "dir_reg_ack");
        wbyte(8'h0F, 1'b0, "dir_data_ack");
        i2c_stop();
        i2c_start();
        wbyte(8'h41, 1'b0, "ptr_raddr_ack");
        rbyte(8'hFF, 1'b0, "ptr_rd_07");
        rbyte(8'h0F, 1'b1, "ptr_rd_06");
        i2c_stop();
        settle();
        cmp("dir_after_write", 32'(dir), 32'hFF0F);

        // Input register pair read with wrap back to 0x00.
        pins = 16'hBEEF;
        i2c_start();
        wbyte(8'h40, 1'b0, "in_addr_ack");
        wbyte(8'h00, 1'b0, "in_reg_ack");
        i2c_start();
        wbyte(8'h41, 1'b0, "in_raddr_ack");
        rbyte(8'hEF, 1'b0, "in_rd_00");
        rbyte(8'hBE, 1'b0, "in_rd_01");
        rbyte(8'hEF, 1'b1, "in_rd_00_wrap");
        i2c_stop();
        settle();

        // Foreign address: target must stay off the bus entirely.
        saw_low   = 1'b0;
        watch_low = 1'b1;
        i2c_start();
        wbyte(8'h42, 1'b1, "miss_addr_nack");
        cmp("miss_busy", 32'(busy), 32'd0);
        wbyte(8'h02, 1'b1, "miss_reg_nack");
        wbyte(8'h55, 1'b1, "miss_data_nack");
        i2c_stop();
        settle();
        watch_low = 1'b0;
        cmp("miss_sda_driven", 32'(saw_low), 32'd0);
        cmp("miss_out", 32'(out), 32'h3CA5);

        // Reset in the middle of a data byte.
        i2c_start();
        wbyte(8'h40, 1'b0, "rst_addr_ack");
        wbyte(8'h02, 1'b0, "rst_reg_ack");
        hbit(1'b1, r);
        hbit(1'b0, r);
        hbit(1'b1, r);
        hbit(1'b0, r);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        cmp("midrst_out", 32'(out), 32'hFFFF);
        cmp("midrst_dir", 32'(dir), 32'hFFFF);
        cmp("midrst_sda_oe_n", 32'(bus.sda_oe_n), 32'd1);
        cmp("midrst_busy", 32'(busy), 32'd0);
        i2c_stop();
        settle();

        upd_q.push_back({16'hFFFF, 16'h12FF});
        i2c_start();
        wbyte(8'h40, 1'b0, "post_addr_ack");
        wbyte(8'h03, 1'b0, "post_reg_ack");
        wbyte(8'h12, 1'b0, "post_data_ack");
        i2c_stop();
        i2c_start();
        wbyte(8'h41, 1'b0, "post_raddr_ack");
        rbyte(8'hFF, 1'b0, "post_rd_02");
        rbyte(8'h12, 1'b1, "post_rd_03");
        i2c_stop();
        settle();
        cmp("post_out", 32'(out), 32'h12FF);

`ifdef I2C_IOEXP_TARGET_IRQ_EN
        i2c_start();
        wbyte(8'h40, 1'b0, "irq_addr_ack");
        wbyte(8'h00, 1'b0, "irq_reg_ack");
        i2c_start();
        wbyte(8'h41, 1'b0, "irq_raddr_ack");
        rbyte(8'hEF, 1'b0, "irq_rd_00");
        rbyte(8'hBE, 1'b1, "irq_rd_01");
        i2c_stop();
        settle();
        cmp("irq_idle", 32'(irq_n), 32'd1);
        pins = 16'hBEE7;
        settle();
        cmp("irq_on_change", 32'(irq_n), 32'd0);
        i2c_start();
        wbyte(8'h40, 1'b0, "irq2_addr_ack");
        wbyte(8'h00, 1'b0, "irq2_reg_ack");
        i2c_start();
        wbyte(8'h41, 1'b0, "irq2_raddr_ack");
        rbyte(8'hE7, 1'b0, "irq2_rd_00");
        cmp("irq_cleared_by_ack", 32'(irq_n), 32'd1);
        rbyte(8'hBE, 1'b1, "irq2_rd_01");
        i2c_stop();
        settle();
        cmp("irq_stays_clear", 32'(irq_n), 32'd1);
`endif

        for (int i = 0; i < 100 && obs_q.size() != 0; i++) @(negedge clk);
        while (exp_v.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_response %s: got none required %h", exp_n.pop_front(), exp_v.pop_front());
        end
        while (upd_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_out_update: got none required %h", upd_q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
